// File: rtl/target_ctl.sv
// rtl/target_ctl.sv - frame-synchronous show/blink/hide sequencer for the target rectangle
module target_ctl #(
  parameter int SHOW_FRAMES = 180,
  parameter int HIDE_FRAMES = 60,
  parameter int WARN_FRAMES = 60,
  parameter int BLINK_SHIFT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk_in,
  input  logic       enable,
  input  logic       hit,
  output logic       rectangle,
  output logic [1:0] state_out,
  output logic       frame_tick,
  output logic [7:0] score,
  output logic [7:0] misses
);

  localparam int MAX_FRAMES = (SHOW_FRAMES > HIDE_FRAMES) ? SHOW_FRAMES : HIDE_FRAMES;
  localparam int CW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_FRAMES - 1);
  localparam logic [CW-1:0] HIDE_LAST  = CW'(HIDE_FRAMES - 1);
  localparam logic [CW-1:0] WARN_START = CW'(SHOW_FRAMES - WARN_FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HIDE = 2'd2
  } state_t;

  state_t        state;
  state_t        nxt_state;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] nxt_cnt;
  logic          vblnk_d;
  logic          tick;
  logic          score_inc;
  logic          miss_inc;

  assign tick      = vblnk_in & ~vblnk_d;
  assign state_out = state;

  // Solid for the early part of SHOW, then toggles every 2**BLINK_SHIFT frames.
  function automatic logic vis(input state_t s, input logic [CW-1:0] c);
    return (s == SHOW) && ((c < WARN_START) || !c[BLINK_SHIFT]);
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_cnt   = frame_cnt;
    score_inc = 1'b0;
    miss_inc  = 1'b0;
    if (!enable) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            nxt_state = SHOW;
            nxt_cnt   = '0;
          end
        end
        SHOW: begin
          // A hit wins over a timeout landing on the same edge.
          if (hit) begin
            nxt_state = HIDE;
            nxt_cnt   = '0;
            score_inc = 1'b1;
          end else if (tick) begin
            if (frame_cnt == SHOW_LAST) begin
              nxt_state = HIDE;
              nxt_cnt   = '0;
              miss_inc  = 1'b1;
            end else begin
              nxt_cnt = frame_cnt + 1'b1;
            end
          end
        end
        HIDE: begin
          if (tick) begin
            if (frame_cnt == HIDE_LAST) begin
              nxt_state = SHOW;
              nxt_cnt   = '0;
            end else begin
              nxt_cnt = frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      vblnk_d    <= 1'b0;
      frame_tick <= 1'b0;
      rectangle  <= 1'b0;
      score      <= 8'd0;
      misses     <= 8'd0;
    end else begin
      vblnk_d    <= vblnk_in;
      frame_tick <= tick;
      state      <= nxt_state;
      frame_cnt  <= nxt_cnt;
      // Visibility only moves on frame boundaries, except a forced blank on disable.
      if (!enable) begin
        rectangle <= 1'b0;
      end else if (tick) begin
        rectangle <= vis(nxt_state, nxt_cnt);
      end
      if (score_inc && (score != 8'hFF)) begin
        score <= score + 8'd1;
      end
      if (miss_inc && (misses != 8'hFF)) begin
        misses <= misses + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_target_ctl.sv
// tb/tb_target_ctl.sv - scoreboard bench for target_ctl with small frame counts
module tb_target_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblnk_in;
  logic       enable;
  logic       hit;
  logic       rectangle;
  logic [1:0] state_out;
  logic       frame_tick;
  logic [7:0] score;
  logic [7:0] misses;

  int total = 0;
  int bad   = 0;
  int exp_score  = 0;
  int exp_misses = 0;

  typedef struct {
    logic       rect;
    logic [1:0] st;
  } exp_t;
  exp_t sb[$];

  target_ctl #(
    .SHOW_FRAMES(4),
    .HIDE_FRAMES(2),
    .WARN_FRAMES(2),
    .BLINK_SHIFT(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vblnk_in  (vblnk_in),
    .enable    (enable),
    .hit       (hit),
    .rectangle (rectangle),
    .state_out (state_out),
    .frame_tick(frame_tick),
    .score     (score),
    .misses    (misses)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  // One vblank pulse; returns at the negedge just after the tick edge.
  task automatic frame(input logic h);
    @(negedge clk);
    vblnk_in = 1'b1;
    hit      = h;
    @(negedge clk);
    vblnk_in = 1'b0;
    hit      = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic pop_check(input string nm, input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s[%0d]: scoreboard empty", nm, idx);
    end else begin
      e = sb.pop_front();
      total++;
      if (rectangle !== e.rect || state_out !== e.st) begin
        bad++;
        $display("FAIL %s[%0d]: rect=%b state=%0d, expected rect=%b state=%0d",
                 nm, idx, rectangle, state_out, e.rect, e.st);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vblnk_in = 1'b0; enable = 1'b0; hit = 1'b0;
    @(negedge clk);
    total++;
    if ({rectangle, state_out, frame_tick, score, misses} !== 20'd0) begin
      bad++;
      $display("FAIL reset_values: got %h, expected 0",
               {rectangle, state_out, frame_tick, score, misses});
    end
    rst = 1'b0;
    frame(1'b0);
    total++;
    if (frame_tick !== 1'b1 || state_out !== 2'd0 || rectangle !== 1'b0) begin
      bad++;
      $display("FAIL tick_disabled: tick=%b state=%0d rect=%b, expected tick=1 state=0 rect=0",
               frame_tick, state_out, rectangle);
    end
  endtask

  task automatic test_timeout();
    logic [6:0] r  = 7'b1000111;
    logic [13:0] s = {2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
    restart();
    for (int i = 0; i < 7; i++) sb.push_back('{r[i], s[2*i +: 2]});
    for (int i = 0; i < 7; i++) begin
      frame(1'b0);
      pop_check("timeout", i + 1);
    end
    exp_misses++;
    total++;
    if (misses !== 8'(exp_misses) || score !== 8'(exp_score)) begin
      bad++;
      $display("FAIL timeout_counts: misses=%0d score=%0d, expected misses=%0d score=%0d",
               misses, score, exp_misses, exp_score);
    end
  endtask

  task automatic test_hit_mid();
    restart();
    sb.push_back('{1'b1, 2'd1});
    sb.push_back('{1'b1, 2'd1});
    for (int i = 0; i < 2; i++) begin
      frame(1'b0);
      pop_check("hitmid_pre", i + 1);
    end
    @(negedge clk); hit = 1'b1;
    @(negedge clk); hit = 1'b0;
    exp_score++;
    total++;
    if (state_out !== 2'd2 || rectangle !== 1'b1 || score !== 8'(exp_score)) begin
      bad++;
      $display("FAIL hitmid_edge: state=%0d rect=%b score=%0d, expected state=2 rect=1 score=%0d",
               state_out, rectangle, score, exp_score);
    end
    @(negedge clk); hit = 1'b1;
    @(negedge clk); hit = 1'b0;
    total++;
    if (score !== 8'(exp_score)) begin
      bad++;
      $display("FAIL hit_in_hide: score=%0d, expected %0d", score, exp_score);
    end
    sb.push_back('{1'b0, 2'd2});
    sb.push_back('{1'b1, 2'd1});
    for (int i = 0; i < 2; i++) begin
      frame(1'b0);
      pop_check("hitmid_post", i + 3);
    end
  endtask

  task automatic test_hit_timeout();
    logic [3:0] r = 4'b0111;
    restart();
    for (int i = 0; i < 4; i++) sb.push_back('{r[i], 2'd1});
    for (int i = 0; i < 4; i++) begin
      frame(1'b0);
      pop_check("hitto_pre", i + 1);
    end
    sb.push_back('{1'b0, 2'd2});
    frame(1'b1);
    pop_check("hitto_tick", 5);
    exp_score++;
    total++;
    if (score !== 8'(exp_score) || misses !== 8'(exp_misses)) begin
      bad++;
      $display("FAIL hitto_counts: score=%0d misses=%0d, expected score=%0d misses=%0d",
               score, misses, exp_score, exp_misses);
    end
  endtask

  task automatic test_enable_drop();
    restart();
    sb.push_back('{1'b1, 2'd1});
    frame(1'b0);
    pop_check("drop_show", 1);
    @(negedge clk); enable = 1'b0; hit = 1'b1;
    @(negedge clk); hit = 1'b0;
    total++;
    if (rectangle !== 1'b0 || state_out !== 2'd0 || score !== 8'(exp_score)) begin
      bad++;
      $display("FAIL drop_edge: rect=%b state=%0d score=%0d, expected rect=0 state=0 score=%0d",
               rectangle, state_out, score, exp_score);
    end
    enable = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (state_out !== 2'd0 || rectangle !== 1'b0) begin
      bad++;
      $display("FAIL drop_wait: state=%0d rect=%b, expected state=0 rect=0", state_out, rectangle);
    end
    sb.push_back('{1'b1, 2'd1});
    frame(1'b0);
    pop_check("drop_reenable", 2);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); hit = 1'b1;
      @(negedge clk); hit = 1'b0;
      frame(1'b0);
      frame(1'b0);
      if (exp_score < 255) exp_score++;
    end
    total++;
    if (score !== 8'(exp_score) || misses !== 8'(exp_misses) || state_out !== 2'd1) begin
      bad++;
      $display("FAIL saturation: score=%0d misses=%0d state=%0d, expected score=%0d misses=%0d state=1",
               score, misses, state_out, exp_score, exp_misses);
    end
  endtask

  task automatic test_vblank_hold();
    int cnt = 0;
    @(negedge clk); vblnk_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frame_tick) cnt++;
    end
    vblnk_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_tick) cnt++;
    end
    total++;
    if (cnt !== 1) begin
      bad++;
      $display("FAIL vblank_hold: ticks=%0d, expected 1", cnt);
    end
  endtask

  task automatic test_async_reset();
    restart();
    sb.push_back('{1'b1, 2'd1});
    frame(1'b0);
    pop_check("areset_show", 1);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({rectangle, state_out, frame_tick, score, misses} !== 20'd0) begin
      bad++;
      $display("FAIL async_reset: got %h, expected 0 before clock edge",
               {rectangle, state_out, frame_tick, score, misses});
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (state_out !== 2'd0 || rectangle !== 1'b0) begin
      bad++;
      $display("FAIL areset_idle: state=%0d rect=%b, expected state=0 rect=0", state_out, rectangle);
    end
    sb.push_back('{1'b1, 2'd1});
    frame(1'b0);
    pop_check("areset_resume", 2);
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_hit_mid();
    test_hit_timeout();
    test_enable_drop();
    test_saturation();
    test_vblank_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
